tuner_meas_ctrl: RTL and testbench

//  Measurement sequencer in front of note_tuner. Times PERIODS rising edges of the

---
 rtl/tuner_pkg.sv | 26 ++
 rtl/tuner_edge_sync.sv | 22 ++
 rtl/tuner_meas_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_tuner_meas_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tuner_pkg.sv
// Shared types for the tuner measurement sequencer: FSM states and the tuner verdict.
package tuner_pkg;

   localparam int NOTE_W    = 4;
   localparam int NUM_NOTES = 12;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      MEASURE,
      HANDOFF,
      WAIT_RES
   } state_e;

   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic              flat;
      logic              sharp;
      logic              in_tune;
   } verdict_t;

   function automatic logic note_in_range(input logic [NOTE_W-1:0] n);
      return int'(n) < NUM_NOTES;
   endfunction

endpackage

// File: rtl/tuner_edge_sync.sv
// Two-flop synchronizer for the squared audio input plus a rising-edge pulse.
module tuner_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic rise_o
);

   logic [2:0] sync_q;
   logic [2:0] sync_d;

   assign sync_d = {sync_q[1:0], sig_i};

   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
   end

   // sync_q[2] is the edge register; the pulse is consumed on the third clk after the rise
   assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tuner_meas_ctrl.sv
// Measurement sequencer in front of note_tuner: times PERIODS input periods, hands the count
// off, collects the verdict and drives the display. Define TUNER_CTRL_HYST_EN for verdict hysteresis.
module tuner_meas_ctrl
   import tuner_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int PERIODS     = 8,
   parameter int TIMEOUT_CYC = 4_000_000,
   parameter int STABLE_N    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              on,
   input  logic              sig_in,
   output logic              meas_valid,
   input  logic              meas_ready,
   output logic [CNT_W-1:0]  meas_cnt,
   output logic              tuner_on,
   input  logic              res_valid,
   input  logic [NOTE_W-1:0] res_note,
   input  logic              res_flat,
   input  logic              res_sharp,
   input  logic              res_in_tune,
   output logic              disp_valid,
   output logic [NOTE_W-1:0] disp_note,
   output logic              disp_flat,
   output logic              disp_sharp,
   output logic              disp_in_tune,
   output logic              silence
);

   localparam int EW = $clog2(PERIODS) + 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   if (PERIODS < 1 || (PERIODS & (PERIODS - 1)) != 0 || STABLE_N < 1) begin : g_bad_cfg
      $error("tuner_meas_ctrl: PERIODS must be a power of two and STABLE_N >= 1");
   end

   state_e            state_q, state_d;
   logic              rise;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [CNT_W-1:0]  meas_q, meas_d;
   logic [EW-1:0]     edge_q, edge_d;
   logic [TW-1:0]     idle_q, idle_d;
   logic              silence_q, silence_d;
   logic              dvld_q, dvld_d;
   verdict_t          disp_q, disp_d;
   verdict_t          res_v;
   logic              timing, timeout, last_rise, cyc_sat, xfer, accept, update;

   tuner_edge_sync u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_i  (sig_in),
      .rise_o (rise)
   );

   assign res_v     = {res_note, res_flat, res_sharp, res_in_tune};
   assign timing    = (state_q == ARM) || (state_q == MEASURE);
   // a rise arriving on the timeout cycle wins
   assign timeout   = timing && !rise && (idle_q == TW'(TIMEOUT_CYC - 1));
   assign last_rise = (state_q == MEASURE) && rise && (edge_q == EW'(PERIODS - 1));
   assign cyc_sat   = &cyc_q;
   assign xfer      = (state_q == HANDOFF) && meas_ready;
   assign accept    = (state_q == WAIT_RES) && res_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!on) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:     state_d = ARM;
            ARM:      if (rise) state_d = MEASURE;
            MEASURE: begin
               if (last_rise)    state_d = cyc_sat ? ARM : HANDOFF;
               else if (timeout) state_d = ARM;
            end
            HANDOFF:  if (xfer)   state_d = WAIT_RES;
            WAIT_RES: if (accept) state_d = ARM;
            default:  state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      tuner_on   = (state_q != IDLE);
      meas_valid = (state_q == HANDOFF);
   end

`ifdef TUNER_CTRL_HYST_EN
   localparam int MW = $clog2(STABLE_N + 1);

   verdict_t      last_q, last_d;
   logic [MW-1:0] match_q, match_d, match_inc;

   always_comb begin
      match_inc = MW'(1);
      if (match_q != '0 && res_v == last_q)
         match_inc = (match_q == MW'(STABLE_N)) ? match_q : match_q + 1'b1;
      last_d  = last_q;
      match_d = match_q;
      if (!on || timeout) begin
         match_d = '0;
      end else if (accept) begin
         last_d  = res_v;
         match_d = match_inc;
      end
   end

   assign update = accept && (match_inc == MW'(STABLE_N));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q  <= '0;
         match_q <= '0;
      end else begin
         last_q  <= last_d;
         match_q <= match_d;
      end
   end
`else
   assign update = accept;
`endif

   always_comb begin
      cyc_d     = cyc_q;
      edge_d    = edge_q;
      meas_d    = meas_q;
      idle_d    = '0;
      silence_d = silence_q;
      dvld_d    = dvld_q;
      disp_d    = disp_q;

      if (timing) idle_d = (rise || timeout) ? '0 : idle_q + 1'b1;

      if (state_q == ARM && rise) begin
         cyc_d  = '0;
         edge_d = '0;
      end
      if (state_q == MEASURE) begin
         if (!cyc_sat)              cyc_d  = cyc_q + 1'b1;
         if (rise)                  edge_d = edge_q + 1'b1;
         if (last_rise && !cyc_sat) meas_d = cyc_q + 1'b1;
      end

      if (rise) silence_d = 1'b0;
      if (timeout) begin
         silence_d = 1'b1;
         dvld_d    = 1'b0;
      end
      if (update) begin
         disp_d = res_v;
         dvld_d = 1'b1;
      end

      if (!on) begin
         idle_d    = '0;
         silence_d = 1'b0;
         dvld_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cyc_q     <= '0;
         edge_q    <= '0;
         meas_q    <= '0;
         idle_q    <= '0;
         silence_q <= 1'b0;
         dvld_q    <= 1'b0;
         disp_q    <= '0;
      end else begin
         cyc_q     <= cyc_d;
         edge_q    <= edge_d;
         meas_q    <= meas_d;
         idle_q    <= idle_d;
         silence_q <= silence_d;
         dvld_q    <= dvld_d;
         disp_q    <= disp_d;
      end
   end

   assign meas_cnt     = meas_q;
   assign silence      = silence_q;
   assign disp_valid   = dvld_q;
   assign disp_note    = disp_q.note;
   assign disp_flat    = disp_q.flat;
   assign disp_sharp   = disp_q.sharp;
   assign disp_in_tune = disp_q.in_tune;

endmodule

// File: tb/tb_tuner_meas_ctrl.sv
// Scoreboarded bench for tuner_meas_ctrl: square-wave input, handshake, silence, on/reset aborts.
module tb_tuner_meas_ctrl;

   localparam int CNT_W       = 32;
   localparam int PERIODS     = 4;
   localparam int TIMEOUT_CYC = 200;
   localparam int STABLE_N    = 3;
   localparam int EXP_CNT     = 80;
`ifdef TUNER_CTRL_HYST_EN
   localparam bit HYST = 1'b1;
`else
   localparam bit HYST = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             on = 1'b0;
   logic             sig_in = 1'b0;
   logic             meas_ready = 1'b0;
   logic             res_valid = 1'b0;
   logic [3:0]       res_note = '0;
   logic             res_flat = 1'b0, res_sharp = 1'b0, res_in_tune = 1'b0;
   logic             meas_valid, tuner_on, disp_valid, disp_flat, disp_sharp, disp_in_tune, silence;
   logic [CNT_W-1:0] meas_cnt;
   logic [3:0]       disp_note;
   logic [42:0]      outs;

   int          n_run = 0;
   int          n_fail = 0;
   int          xfer_n = 0;
   int          ph = 0;
   bit          sq_en = 1'b0;
   int unsigned sb[$];

   tuner_meas_ctrl #(
      .CNT_W(CNT_W), .PERIODS(PERIODS), .TIMEOUT_CYC(TIMEOUT_CYC), .STABLE_N(STABLE_N)
   ) dut (
      .clk(clk), .rst_n(rst_n), .on(on), .sig_in(sig_in),
      .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_cnt(meas_cnt),
      .tuner_on(tuner_on), .res_valid(res_valid), .res_note(res_note),
      .res_flat(res_flat), .res_sharp(res_sharp), .res_in_tune(res_in_tune),
      .disp_valid(disp_valid), .disp_note(disp_note), .disp_flat(disp_flat),
      .disp_sharp(disp_sharp), .disp_in_tune(disp_in_tune), .silence(silence)
   );

   assign outs = {meas_valid, tuner_on, disp_valid, disp_note, disp_flat, disp_sharp,
                  disp_in_tune, silence, meas_cnt};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // square wave, period 20 clk, first rise right after enable
   initial forever begin
      @(negedge clk);
      if (sq_en) begin
         sig_in = (ph < 10);
         ph     = (ph + 1) % 20;
      end
   end

   // transfer monitor: valid&ready at the negedge means a transfer on the next posedge
   initial forever begin
      @(negedge clk);
      if (rst_n && meas_valid && meas_ready) begin
         xfer_n++;
         if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
         else                chk("meas_cnt", meas_cnt, sb.pop_front());
      end
   end

   task automatic wait_xfer(input string tag);
      int n0 = xfer_n;
      int k  = 0;
      while (xfer_n == n0 && k < 400) begin
         step();
         k++;
      end
      if (xfer_n == n0) chk(tag, xfer_n - n0, 1);
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (!meas_valid && k < 400) begin
         step();
         k++;
      end
      if (!meas_valid) chk(tag, meas_valid, 1);
   endtask

   task automatic meas(input string tag);
      sb.push_back(EXP_CNT);
      wait_xfer(tag);
   endtask

   task automatic verdict(input logic [3:0] n, input logic f, input logic s, input logic t);
      res_note = n; res_flat = f; res_sharp = s; res_in_tune = t;
      res_valid = 1'b1;
      step();
      res_valid = 1'b0;
   endtask

   initial begin
      automatic logic [3:0] notes[5] = '{4'd4, 4'd4, 4'd7, 4'd7, 4'd7};
      int n0;

      step(3);
      chk("rst_outs", outs, 0);
      rst_n = 1'b1;
      on    = 1'b1;
      step();
      chk("arm_tuner_on", tuner_on, 1);
      meas_ready = 1'b1;
      step();
      ph = 0; sq_en = 1'b1;

      // basic measurement and verdict
      for (int r = 0; r < (HYST ? STABLE_N : 1); r++) begin
         meas("t1_xfer");
         verdict(4'd9, 1'b0, 1'b0, 1'b1);
      end
      chk("t1_disp_valid", disp_valid, 1);
      chk("t1_disp_note", disp_note, 9);
      chk("t1_disp_in_tune", disp_in_tune, 1);
      chk("t1_disp_flat", disp_flat, 0);

      // verdict strobe while measuring is ignored
      step(30);
      verdict(4'd3, 1'b1, 1'b0, 1'b0);
      chk("ign_note", disp_note, 9);
      chk("ign_flat", disp_flat, 0);

      // back-pressure
      meas_ready = 1'b0;
      sb.push_back(EXP_CNT);
      wait_valid("t2_valid");
      for (int i = 0; i < 15; i++) begin
         chk("t2_hold_valid", meas_valid, 1);
         chk("t2_hold_cnt", meas_cnt, EXP_CNT);
         step();
      end
      n0 = xfer_n;
      meas_ready = 1'b1;
      wait_xfer("t2_xfer");
      chk("t2_valid_drop", meas_valid, 0);
      step(20);
      chk("t2_one_xfer", xfer_n - n0, 1);
      verdict(4'd9, 1'b0, 1'b0, 1'b1);

      // silence: single rise, then nothing
      sq_en = 1'b0; sig_in = 1'b0;
      step(10);
      sig_in = 1'b1;
      for (int i = 0; i < 202; i++) begin
         step();
         if (i == 4) sig_in = 1'b0;
      end
      chk("t3_pre_silence", silence, 0);
      step();
      chk("t3_silence", silence, 1);
      chk("t3_disp_off", disp_valid, 0);
      sb.push_back(EXP_CNT);
      ph = 0; sq_en = 1'b1;
      step(2);
      chk("t3_still_silent", silence, 1);
      step();
      chk("t3_silence_clr", silence, 0);
      wait_xfer("t3_xfer");
      verdict(4'd9, 1'b0, 1'b0, 1'b1);

      // on=0 mid-MEASURE
      step(40);
      on = 1'b0;
      step();
      chk("t4m_tuner_on", tuner_on, 0);
      chk("t4m_meas_valid", meas_valid, 0);
      chk("t4m_disp_valid", disp_valid, 0);
      on = 1'b1;
      meas("t4m_fresh");
      verdict(4'd9, 1'b0, 1'b0, 1'b1);

      // on=0 mid-HANDOFF
      meas_ready = 1'b0;
      sb.push_back(EXP_CNT);
      wait_valid("t4h_valid");
      on = 1'b0;
      void'(sb.pop_back());
      step();
      chk("t4h_meas_valid", meas_valid, 0);
      chk("t4h_tuner_on", tuner_on, 0);
      chk("t4h_disp_valid", disp_valid, 0);
      on = 1'b1;
      meas_ready = 1'b1;
      meas("t4h_fresh");
      verdict(4'd9, 1'b0, 1'b0, 1'b1);

      // verdict sequence 4,4,7,7,7
      for (int i = 0; i < 5; i++) begin
         meas("t5_xfer");
         verdict(notes[i], 1'b0, 1'b0, 1'b0);
         chk("t5_disp_valid", disp_valid, HYST ? (i == 4) : 1);
         chk("t5_disp_note", disp_note, HYST ? ((i == 4) ? 7 : 9) : notes[i]);
      end

      // reset while waiting for the verdict
      meas("t6_xfer");
      sq_en = 1'b0; sig_in = 1'b0;
      step(3);
      rst_n = 1'b0;
      step();
      chk("t6_rst_outs", outs, 0);
      rst_n = 1'b1;
      step();
      chk("t6_rearm", tuner_on, 1);
      ph = 0; sq_en = 1'b1;
      meas("t6_recover");

      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_run);
      $fatal(1);
   end

endmodule
